// File: rtl/fetch_instruction_queue.sv
// Fetch-to-decode instruction queue: in-order FIFO of (PC, instruction) pairs
// with whole-queue flush on redirect and no push-to-pop bypass.
module fetch_instruction_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_instruction,
  input  logic             flush,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [31:0]      pop_pc,
  output logic [31:0]      pop_instruction,
  output logic             pop_misaligned,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] pc_mem_q   [DEPTH];
  logic [31:0] insn_mem_q [DEPTH];
  logic        mis_mem_q  [DEPTH];

  logic push_fire, pop_fire;

  // Handshakes look only at registered occupancy, never at the opposite port.
  assign push_ready = (count_q != FULL_CNT);
  assign pop_valid  = (count_q != '0);
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge CLK) begin
    if (push_fire && !flush) begin
      pc_mem_q[wr_ptr_q]   <= push_pc;
      insn_mem_q[wr_ptr_q] <= push_instruction;
      mis_mem_q[wr_ptr_q]  <= |push_pc[1:0];
    end
  end

  assign pop_pc          = pop_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign pop_instruction = pop_valid ? insn_mem_q[rd_ptr_q] : 32'h0;
  assign pop_misaligned  = pop_valid & mis_mem_q[rd_ptr_q];
  assign count           = count_q;

endmodule

// File: tb/tb_fetch_instruction_queue.sv
// Directed bench for fetch_instruction_queue: reset, fill/drain, streaming,
// flush, empty pop and misaligned-PC flagging.
module tb_fetch_instruction_queue;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_instruction;
  logic        flush;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_pc;
  logic [31:0] pop_instruction;
  logic        pop_misaligned;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_instruction_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_pc          (push_pc),
    .push_instruction (push_instruction),
    .flush            (flush),
    .pop_valid        (pop_valid),
    .pop_ready        (pop_ready),
    .pop_pc           (pop_pc),
    .pop_instruction  (pop_instruction),
    .pop_misaligned   (pop_misaligned),
    .count            (count)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are inspected 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic [31:0] insn);
    push_valid = 1'b1;
    push_pc = pc;
    push_instruction = insn;
    pop_ready = 1'b0;
    step();
    push_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    idle();
    push_pc = '0;
    push_instruction = '0;
    #12;
    n_checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1 || pop_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_init got count=%0d pv=%b pr=%b pc=%h want 0 0 1 0", count, pop_valid, push_ready, pop_pc);
    end
    RST_N = 1'b1;
    step();
    do_push(32'h40, 32'h1);
    do_push(32'h44, 32'h2);
    do_push(32'h48, 32'h3);
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_prefill got count=%0d want 3", count);
    end
    // Assert reset mid-cycle and check before any clock edge.
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1 || pop_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async got count=%0d pv=%b pr=%b pc=%h want 0 0 1 0", count, pop_valid, push_ready, pop_pc);
    end
    step();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) do_push(32'(4*i), 32'h13 + 32'(i));
    n_checks++;
    if (count !== 3'd4 || push_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state got count=%0d pr=%b want 4 0", count, push_ready);
    end
    do_push(32'h10, 32'h99);
    n_checks++;
    if (count !== 3'd4 || pop_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL full_refuse got count=%0d head=%h want 4 0", count, pop_pc);
    end
    // Push offered while full and a pop fires: push must still be refused.
    n_checks++;
    if (pop_pc !== 32'h0 || pop_instruction !== 32'h13) begin
      n_fail++;
      $display("FAIL drain_0 got pc=%h insn=%h want 0 13", pop_pc, pop_instruction);
    end
    push_valid = 1'b1;
    push_pc = 32'h10;
    pop_ready = 1'b1;
    step();
    push_valid = 1'b0;
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL full_pop_push got count=%0d want 3", count);
    end
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (pop_valid !== 1'b1 || pop_pc !== 32'(4*i) || pop_instruction !== 32'h13 + 32'(i)) begin
        n_fail++;
        $display("FAIL drain_%0d got pv=%b pc=%h insn=%h want 1 %h %h", i, pop_valid, pop_pc, pop_instruction, 4*i, 32'h13 + 32'(i));
      end
      step();
    end
    pop_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty got count=%0d pv=%b want 0 0", count, pop_valid);
    end
  endtask

  task automatic test_streaming();
    do_push(32'h200, 32'hA0);
    for (int i = 0; i < 10; i++) begin
      push_valid = 1'b1;
      push_pc = 32'h204 + 32'(4*i);
      push_instruction = 32'hA1 + 32'(i);
      pop_ready = 1'b1;
      n_checks++;
      if (pop_pc !== 32'h200 + 32'(4*i) || pop_instruction !== 32'hA0 + 32'(i)) begin
        n_fail++;
        $display("FAIL stream_%0d got pc=%h insn=%h want %h %h", i, pop_pc, pop_instruction, 32'h200 + 32'(4*i), 32'hA0 + 32'(i));
      end
      step();
      n_checks++;
      if (count !== 3'd1) begin
        n_fail++;
        $display("FAIL stream_count_%0d got %0d want 1", i, count);
      end
    end
    push_valid = 1'b0;
    n_checks++;
    if (pop_pc !== 32'h228) begin
      n_fail++;
      $display("FAIL stream_last got pc=%h want 228", pop_pc);
    end
    step();
    pop_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL stream_end got count=%0d want 0", count);
    end
  endtask

  task automatic test_flush();
    do_push(32'h300, 32'h1);
    do_push(32'h304, 32'h2);
    do_push(32'h308, 32'h3);
    flush = 1'b1;
    push_valid = 1'b1;
    push_pc = 32'h20;
    push_instruction = 32'h20;
    step();
    flush = 1'b0;
    push_valid = 1'b0;
    n_checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || pop_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_clear got count=%0d pv=%b pc=%h want 0 0 0", count, pop_valid, pop_pc);
    end
    do_push(32'h100, 32'h55);
    n_checks++;
    if (count !== 3'd1 || pop_valid !== 1'b1 || pop_pc !== 32'h100 || pop_instruction !== 32'h55) begin
      n_fail++;
      $display("FAIL flush_after got count=%0d pv=%b pc=%h insn=%h want 1 1 100 55", count, pop_valid, pop_pc, pop_instruction);
    end
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
  endtask

  task automatic test_empty_pop();
    pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (count !== 3'd0 || pop_valid !== 1'b0 || pop_pc !== 32'h0) begin
        n_fail++;
        $display("FAIL empty_pop_%0d got count=%0d pv=%b pc=%h want 0 0 0", i, count, pop_valid, pop_pc);
      end
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    do_push(32'h6, 32'h77);
    n_checks++;
    if (pop_misaligned !== 1'b1 || pop_pc !== 32'h6) begin
      n_fail++;
      $display("FAIL misaligned_head got mis=%b pc=%h want 1 6", pop_misaligned, pop_pc);
    end
    do_push(32'h8, 32'h78);
    n_checks++;
    if (pop_misaligned !== 1'b1 || pop_pc !== 32'h6 || count !== 3'd2) begin
      n_fail++;
      $display("FAIL misaligned_hold got mis=%b pc=%h count=%0d want 1 6 2", pop_misaligned, pop_pc, count);
    end
    pop_ready = 1'b1;
    step();
    n_checks++;
    if (pop_misaligned !== 1'b0 || pop_pc !== 32'h8) begin
      n_fail++;
      $display("FAIL aligned_head got mis=%b pc=%h want 0 8", pop_misaligned, pop_pc);
    end
    step();
    pop_ready = 1'b0;
    n_checks++;
    if (pop_misaligned !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL misaligned_empty got mis=%b count=%0d want 0 0", pop_misaligned, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_flush();
    test_empty_pop();
    test_misaligned();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
